// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width,
// reset PC, the NOP bubble encoding and the fetch FSM state type.
package if_fetch_unit_pkg;

    localparam int XLEN = 32;

    // PC value loaded by reset
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

    // addi x0, x0, 0 -- the bubble shown to ID whenever no instruction is held
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // REQ   : request presented on the memory port, waiting for acceptance
    // WAIT  : request accepted, waiting for its response
    // HOLD  : instruction buffered and presented to IF/ID until consumed
    // DRAIN : a response is still owed for a request made stale by a redirect
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    // Sequential PC increment; wraps silently at 2^XLEN
    function automatic logic [XLEN-1:0] pcPlus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the PC, keeps at most one instruction-memory
// request in flight, and feeds PC, PC+4 and the fetched instruction to the
// IF/ID pipeline register. IF_Flush tells IF/ID to load a NOP bubble in any
// cycle where no valid instruction is held or a redirect is taking place.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] BOOT_PC = RESET_PC
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            IF_ID_Write,
    input  logic            EX_Redirect,
    input  logic [XLEN-1:0] EX_Target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] IF_PC,
    output logic [XLEN-1:0] IF_PC_4,
    output logic [XLEN-1:0] IF_instruction,
    output logic            IF_Flush
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instrBuf_q;
    logic            outValid_q;

    // A redirect must drain rather than restart if memory still owes a
    // response after this edge: an accepted-but-unanswered request in WAIT,
    // a request being accepted right now in REQ, or an unfinished DRAIN.
    logic outstandingAfterEdge;

    // Decide whether a redirect this cycle leaves a response in flight
    always_comb begin
        outstandingAfterEdge = 1'b0;
        unique case (state_q)
            ST_REQ:   outstandingAfterEdge = imem_ready;
            ST_WAIT:  outstandingAfterEdge = ~imem_rvalid;
            ST_DRAIN: outstandingAfterEdge = ~imem_rvalid;
            ST_HOLD:  outstandingAfterEdge = 1'b0;
            default:  outstandingAfterEdge = 1'b0;
        endcase
    end

    // Fetch FSM: PC, instruction buffer, valid flag and state update together
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_REQ;
            pc_q       <= BOOT_PC;
            instrBuf_q <= NOP_INSTR;
            outValid_q <= 1'b0;
        end else if (EX_Redirect) begin
            pc_q       <= EX_Target;
            instrBuf_q <= NOP_INSTR;
            outValid_q <= 1'b0;
            state_q    <= outstandingAfterEdge ? ST_DRAIN : ST_REQ;
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (imem_ready) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        instrBuf_q <= imem_rdata;
                        outValid_q <= 1'b1;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (IF_ID_Write) begin
                        pc_q       <= pcPlus4(pc_q);
                        instrBuf_q <= NOP_INSTR;
                        outValid_q <= 1'b0;
                        state_q    <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) begin
                        state_q <= ST_REQ;
                    end
                end
                default: begin
                    state_q <= ST_REQ;
                end
            endcase
        end
    end

    // Memory port is driven from state only; held low while reset is asserted
    always_comb begin
        imem_req  = (state_q == ST_REQ) & ~reset;
        imem_addr = pc_q;
    end

    // IF/ID-facing outputs; only IF_Flush reacts combinationally to a redirect
    always_comb begin
        IF_PC          = pc_q;
        IF_PC_4        = pcPlus4(pc_q);
        IF_instruction = outValid_q ? instrBuf_q : NOP_INSTR;
        IF_Flush       = EX_Redirect | ~outValid_q;
    end

endmodule
